traffic_phase_controller: RTL
=============================

# traffic_phase_controller

Phase sequencer for a two-road (NS/EW) intersection with a pedestrian WALK phase. It consumes the one-second `tick` level from the clock divider and rising-edge detects it internally. It steps a state machine through green, yellow and all-red phases with per-phase second counters, and drives the lamp outputs directly. It sits between the divider and the board lamp/LED pins.

## Interface
- `GREEN_SEC`, 10, green duration in ticks (≥1)
- `YELLOW_SEC`, 3, yellow duration in ticks (≥1)
- `ALLRED_SEC`, 1, all-red clearance duration in ticks (≥1)
- `WALK_SEC`, 5, pedestrian WALK duration in ticks (≥1)
- `CNT_W`, 8, width of the seconds counter; every duration must be < 2^CNT_W
- `clk`  in  1  system clock
- `reset_sync`  in  1  asynchronous, active-high reset
- `tick`  in  1  divider enable level; each rising edge = one second
- `ped_req`  in  1  pedestrian button, pulse or level; latched internally
- `ns_light`  out  3  NS lamps {red, yellow, green}, one-hot
- `ew_light`  out  3  EW lamps {red, yellow, green}, one-hot
- `walk`  out  1  pedestrian WALK lamp
- `ped_ack`  out  1  one-cycle pulse when a latched request is served
- `sec_left`  out  CNT_W  ticks remaining in the current phase
- `state_o`  out  3  current state encoding (debug)

## Operation
- Edge detect: `tick_q` is registered from `tick`. `tick_rise = tick & ~tick_q`. `tick_q` resets to 0.
- States and encodings: NS_G=0, NS_Y=1, AR=2, EW_G=3, EW_Y=4, WALK=5, FLASH=6 (FLASH only with the macro).
- `dir` register: 0 means the next green is EW, 1 means the next green is NS.
- Sequence:
  - NS_G → NS_Y → AR(dir=0).
  - AR → WALK if `pend` is set, otherwise → EW_G (dir=0) or NS_G (dir=1).
  - EW_G → EW_Y → AR(dir=1).
  - WALK → EW_G (dir=0) or NS_G (dir=1).
- Counter behaviour:
  - On state entry, `sec_left` loads that state's duration.
  - On each `tick_rise`: if `sec_left==1`, transition and load the next duration; otherwise decrement.
  - `sec_left` never reads 0 in a timed state.
- Lamps:
  - NS_G: ns=001, ew=100.
  - NS_Y: ns=010, ew=100.
  - EW_G: ns=100, ew=001.
  - EW_Y: ns=100, ew=010.
  - AR and WALK: ns=100, ew=100.
  - `walk`=1 only in WALK.
- Pedestrian request:
  - `pend` is set by `ped_req` sampled high in any state except WALK.
  - `pend` is cleared on the AR→WALK transition, together with a one-cycle `ped_ack`.
  - `ped_req` high on that same transition edge is ignored; clear wins.
  - `ped_req` during WALK is ignored.
- A conflicting green (both roads green or yellow) is unreachable by construction. Verification asserts this.

## Timing
- Reset values:
  - state=NS_G, dir=0, `sec_left`=GREEN_SEC, `pend`=0, `tick_q`=0.
  - ns_light=001, ew_light=100, walk=0, ped_ack=0, state_o=0.
- Reset is asynchronous and takes effect mid-phase immediately. After release, the first `tick_rise` decrements from GREEN_SEC.
- Transition latency: state, lamps and `sec_left` update on the same clock edge at which `tick` is first sampled high with `tick_q`=0. That is one clk after `tick` rises.
- A `tick` held high produces exactly one `tick_rise`. `tick` low produces none.
- `ped_ack` is high for exactly the one cycle following the AR→WALK edge.
- `ped_req` is sampled every clk, independent of `tick`. Its latency to `pend` is one clk.
- Full cycle without pedestrians: 2·(GREEN_SEC+YELLOW_SEC+ALLRED_SEC) ticks.

## Configuration
- `TLC_FLASH_EN` defined:
  - Adds input port `flash` (1 bit).
  - On a `tick_rise` with `flash`=1, any state goes to FLASH.
  - In FLASH: ew=100. ns toggles between 010 and 000 on every `tick_rise`, starting at 010 on entry. `sec_left` holds 0 and `walk`=0. `pend` is still latched.
  - On a `tick_rise` with `flash`=0 in FLASH: go to AR with dir=1 and `sec_left`=ALLRED_SEC.
- Not defined: no `flash` port, FLASH state absent, and state_o never reads 6.

## Test plan
All scenarios use GREEN_SEC=3, YELLOW_SEC=2, ALLRED_SEC=1, WALK_SEC=2, with `tick` rising every 10 clk.
1. Reset, no requests → `sec_left` NS_G 3,2,1; NS_Y 2,1; AR 1; EW_G 3,2,1; EW_Y 2,1; AR 1; back to NS_G after exactly 12 tick edges. Lamp values match the Operation list.
2. `ped_req` pulsed 1 clk during NS_G → after NS_Y and AR: `ped_ack` for 1 clk, WALK with walk=1 and both roads 100 for 2 ticks, then EW_G.
3. `ped_req` held high through WALK → exactly one `ped_ack` and one WALK. The next AR (before NS_G) goes straight to NS_G.
4. `tick` held high for 50 clk → a single decrement only. Reset asserted mid-EW_Y → next clk shows ns=001, ew=100, `sec_left`=3.
5. With `TLC_FLASH_EN`: assert `flash` during EW_G → next `tick_rise` enters FLASH with ns=010, then 000, 010 on successive ticks. Deassert `flash` → AR then NS_G.
6. Every cycle in all scenarios: never ns≠100 and ew≠100 simultaneously; `sec_left`≥1 outside FLASH.

Source files
------------

// File: rtl/traffic_phase_controller.sv
// Two-road intersection phase sequencer with a pedestrian WALK phase, driven by a rising-edge-detected 1 s tick.
// Optional flashing-yellow override is built when TLC_FLASH_EN is defined.
module traffic_phase_controller #(
  parameter int GREEN_SEC  = 10,
  parameter int YELLOW_SEC = 3,
  parameter int ALLRED_SEC = 1,
  parameter int WALK_SEC   = 5,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic             tick,
  input  logic             ped_req,
`ifdef TLC_FLASH_EN
  input  logic             flash,
`endif
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic             ped_ack,
  output logic [CNT_W-1:0] sec_left,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_NS_G  = 3'd0,
    S_NS_Y  = 3'd1,
    S_AR    = 3'd2,
    S_EW_G  = 3'd3,
    S_EW_Y  = 3'd4,
    S_WALK  = 3'd5
`ifdef TLC_FLASH_EN
    , S_FLASH = 3'd6
`endif
  } state_t;

  localparam logic [CNT_W-1:0] G_D   = CNT_W'(GREEN_SEC);
  localparam logic [CNT_W-1:0] Y_D   = CNT_W'(YELLOW_SEC);
  localparam logic [CNT_W-1:0] AR_D  = CNT_W'(ALLRED_SEC);
  localparam logic [CNT_W-1:0] W_D   = CNT_W'(WALK_SEC);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state, state_n;
  logic             dir, dir_n;
  logic [CNT_W-1:0] sec_n;
  logic             pend, pend_n;
  logic             ack_n;
  logic             tick_q;
  logic             tick_rise;
  logic             step;
`ifdef TLC_FLASH_EN
  logic             flash_ph, flash_ph_n;
`endif

  assign tick_rise = tick & ~tick_q;

  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      state    <= S_NS_G;
      dir      <= 1'b0;
      sec_left <= G_D;
      pend     <= 1'b0;
      ped_ack  <= 1'b0;
      tick_q   <= 1'b0;
`ifdef TLC_FLASH_EN
      flash_ph <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      dir      <= dir_n;
      sec_left <= sec_n;
      pend     <= pend_n;
      ped_ack  <= ack_n;
      tick_q   <= tick;
`ifdef TLC_FLASH_EN
      flash_ph <= flash_ph_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    dir_n   = dir;
    sec_n   = sec_left;
    pend_n  = pend;
    ack_n   = 1'b0;
    step    = tick_rise;
`ifdef TLC_FLASH_EN
    flash_ph_n = flash_ph;
`endif
    if (ped_req && state != S_WALK) pend_n = 1'b1;
`ifdef TLC_FLASH_EN
    // Flash overrides the normal phase timing in every state.
    if (tick_rise) begin
      if (flash) begin
        step       = 1'b0;
        state_n    = S_FLASH;
        sec_n      = '0;
        flash_ph_n = (state == S_FLASH) ? ~flash_ph : 1'b1;
      end else if (state == S_FLASH) begin
        step    = 1'b0;
        state_n = S_AR;
        dir_n   = 1'b1;
        sec_n   = AR_D;
      end
    end
`endif
    if (step) begin
      if (sec_left == ONE) begin
        case (state)
          S_NS_G: begin state_n = S_NS_Y; sec_n = Y_D; end
          S_NS_Y: begin state_n = S_AR; sec_n = AR_D; dir_n = 1'b0; end
          S_EW_G: begin state_n = S_EW_Y; sec_n = Y_D; end
          S_EW_Y: begin state_n = S_AR; sec_n = AR_D; dir_n = 1'b1; end
          S_AR: begin
            if (pend) begin
              // Clearing here takes priority over a request sampled on this edge.
              state_n = S_WALK;
              sec_n   = W_D;
              pend_n  = 1'b0;
              ack_n   = 1'b1;
            end else begin
              state_n = dir ? S_NS_G : S_EW_G;
              sec_n   = G_D;
            end
          end
          S_WALK: begin state_n = dir ? S_NS_G : S_EW_G; sec_n = G_D; end
          default: begin state_n = S_NS_G; sec_n = G_D; end
        endcase
      end else begin
        sec_n = sec_left - ONE;
      end
    end
  end

  always_comb begin
    ns_light = 3'b100;
    ew_light = 3'b100;
    walk     = 1'b0;
    case (state)
      S_NS_G: ns_light = 3'b001;
      S_NS_Y: ns_light = 3'b010;
      S_EW_G: ew_light = 3'b001;
      S_EW_Y: ew_light = 3'b010;
      S_WALK: walk     = 1'b1;
`ifdef TLC_FLASH_EN
      S_FLASH: ns_light = flash_ph ? 3'b010 : 3'b000;
`endif
      default: ;
    endcase
  end

  assign state_o = state;

endmodule
